// File: rtl/median_pkg.sv
// Shared definitions for the 3x3 median filter: window geometry and slot indexing.
// The median core imports the same idx() so both sides agree on the window packing.
package median_pkg;

  localparam int PIXEL_W    = 8;
  localparam int WIN_TAPS   = 9;
  localparam int CENTRE_IDX = 4;

  // Slot index within the packed window word; dy=0 is the top line, dx=0 the left column.
  function automatic int idx(input int dy, input int dx);
    return 3 * dy + dx;
  endfunction

endpackage

// File: rtl/median_line_buf.sv
// One image line of pixel storage, addressed by column.
// Read data is combinational, so the old value is seen in the same cycle it is overwritten.
module median_line_buf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rd_data = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/median_window_gen.sv
// Builds a 3x3 neighbourhood for every interior pixel of a raster stream using two line
// buffers and a shifting window; emits one registered window per accepted interior pixel.
module median_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIXEL_W    = median_pkg::PIXEL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [PIXEL_W-1:0]     pixel_in,
  output logic                   win_valid,
  output logic [9*PIXEL_W-1:0]   win_out,
  output logic                   frame_done
);
  import median_pkg::*;

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]            r_col;
  logic [ROW_W-1:0]            r_row;
  logic                        r_win_valid;
  logic                        r_frame_done;
  logic [WIN_TAPS*PIXEL_W-1:0] r_win_out;
  logic [PIXEL_W-1:0]          r_win [3][3];

  logic                        w_start;
  logic [COL_W-1:0]            w_col;
  logic [COL_W-1:0]            w_col_nxt;
  logic [ROW_W-1:0]            w_row;
  logic [ROW_W-1:0]            w_row_nxt;
  logic                        w_col_last;
  logic                        w_last;
  logic                        w_emit;
  logic [PIXEL_W-1:0]          w_lb1_rd;
  logic [PIXEL_W-1:0]          w_lb2_rd;
  logic [PIXEL_W-1:0]          w_new_col [3];
  logic [WIN_TAPS*PIXEL_W-1:0] w_win_word;

  // A start-of-frame beat is position (0,0) no matter where the counters were.
  always_comb begin
    w_start    = in_valid && in_sof;
    w_col      = w_start ? '0 : r_col;
    w_row      = w_start ? '0 : r_row;
    w_col_last = (w_col == COL_LAST);
    w_last     = w_col_last && (w_row == ROW_LAST);
    w_col_nxt  = w_col_last ? '0 : w_col + 1'b1;
    if (!w_col_last) begin
      w_row_nxt = w_row;
    end else if (w_row == ROW_LAST) begin
      w_row_nxt = '0;
    end else begin
      w_row_nxt = w_row + 1'b1;
    end
    w_emit = in_valid && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
  end

  median_line_buf #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_W),
    .AW    (COL_W)
  ) u_lb1 (
    .clk       (clk),
    .i_wr_en   (in_valid),
    .i_addr    (w_col),
    .i_wr_data (pixel_in),
    .o_rd_data (w_lb1_rd)
  );

  median_line_buf #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_W),
    .AW    (COL_W)
  ) u_lb2 (
    .clk       (clk),
    .i_wr_en   (in_valid),
    .i_addr    (w_col),
    .i_wr_data (w_lb1_rd),
    .o_rd_data (w_lb2_rd)
  );

  // Emitted word is the window as it will look after this beat's shift.
  always_comb begin
    w_new_col[0] = w_lb2_rd;
    w_new_col[1] = w_lb1_rd;
    w_new_col[2] = pixel_in;
    w_win_word   = '0;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 2; dx++) begin
        w_win_word[PIXEL_W*idx(dy, dx) +: PIXEL_W] = r_win[dy][dx+1];
      end
      w_win_word[PIXEL_W*idx(dy, 2) +: PIXEL_W] = w_new_col[dy];
    end
  end

  // Window contents need no reset: border suppression keeps stale columns from being emitted.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int dy = 0; dy < 3; dy++) begin
        r_win[dy][0] <= r_win[dy][1];
        r_win[dy][1] <= r_win[dy][2];
        r_win[dy][2] <= w_new_col[dy];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_win_out    <= '0;
    end else begin
      r_win_valid  <= w_emit;
      r_frame_done <= w_emit && w_last;
      if (in_valid) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
      end
      if (w_emit) begin
        r_win_out <= w_win_word;
      end
    end
  end

  assign win_valid  = r_win_valid;
  assign win_out    = r_win_out;
  assign frame_done = r_frame_done;

endmodule
